// File: rtl/alu16_flags.sv
// alu16_flags: 16-bit, 8-operation execute ALU with registered result and
// zero/negative flags. The result and flags load on each rising clk edge
// and clear asynchronously while rst_n is low.
//
// Two implementations of the same function live in this file. They must
// match on every output in every cycle:
//   alu16_flags      - behavioural reference (integrated as q2)
//   alu16_flags_gate - gate-level datapath built from one bit-slice cell
//                      per result bit (integrated as syq2)
//
// Ports (identical on both):
//   clk   in   rising-edge clock
//   rst_n in   async active-low reset (w=0, zer=1, neg=0)
//   opc   in   [2:0] op: ADD SUB AND OR XOR NOT SHL SAR
//   ina   in   [WIDTH-1:0] operand A
//   inb   in   [WIDTH-1:0] operand B
//   inc   in   carry-in / borrow-in / shift-in bit
//   w     out  [WIDTH-1:0] registered result
//   zer   out  registered (w == 0)
//   neg   out  registered w[WIDTH-1]

module alu16_flags #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opc,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             inc,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg
);
  logic [WIDTH-1:0] w_d, w_q;
  logic             zer_q, neg_q;

  always_comb begin
    w_d = '0;
    unique case (opc)
      3'd0: w_d = ina + inb + WIDTH'(inc);
      3'd1: w_d = ina - inb - WIDTH'(inc);
      3'd2: w_d = ina & inb;
      3'd3: w_d = ina | inb;
      3'd4: w_d = ina ^ inb;
      3'd5: w_d = ~ina;
      3'd6: w_d = {ina[WIDTH-2:0], inc};
      3'd7: w_d = {ina[WIDTH-1], ina[WIDTH-1:1]};
      default: w_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      zer_q <= 1'b1;
      neg_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      zer_q <= (w_d == '0);
      neg_q <= w_d[WIDTH-1];
    end
  end

  assign w   = w_q;
  assign zer = zer_q;
  assign neg = neg_q;
endmodule

// One result bit of the gate-level ALU. Every op result is formed in
// parallel and merged with an AND-OR mux on a one-hot select, so a
// don't-care operand feeding an unselected op is masked by a 0 select and
// cannot reach r.
module alu16_flags_slice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       sub,     // invert B for subtraction
  input  logic       shl_in,  // neighbour bit for SHL
  input  logic       sar_in,  // neighbour bit for SAR
  input  logic [7:0] sel,     // one-hot opcode
  output logic       r,
  output logic       cout
);
  logic bx, p, s;

  assign bx   = b ^ sub;
  assign p    = a ^ bx;
  assign s    = p ^ cin;
  assign cout = (a & bx) | (cin & p);

  assign r = ((sel[0] | sel[1]) & s)
           | (sel[2] & (a & b))
           | (sel[3] & (a | b))
           | (sel[4] & (a ^ b))
           | (sel[5] & ~a)
           | (sel[6] & shl_in)
           | (sel[7] & sar_in);
endmodule

module alu16_flags_gate #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opc,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             inc,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg
);
  logic [7:0]       sel;
  logic             sub;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] shl_in, sar_in, w_d, w_q;
  logic             zer_q, neg_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign sel[gi] = &(opc ~^ 3'(gi));
    end
  endgenerate

  // a - b - inc == a + ~b + ~inc, so SUB inverts both B and the carry-in.
  assign sub      = sel[1];
  assign carry[0] = inc ^ sub;
  assign shl_in   = {ina[WIDTH-2:0], inc};
  assign sar_in   = {ina[WIDTH-1], ina[WIDTH-1:1]};

  alu16_flags_slice u_sl [WIDTH-1:0] (
    .a      (ina),
    .b      (inb),
    .cin    (carry[WIDTH-1:0]),
    .sub    (sub),
    .shl_in (shl_in),
    .sar_in (sar_in),
    .sel    (sel),
    .r      (w_d),
    .cout   (carry[WIDTH:1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      zer_q <= 1'b1;
      neg_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      zer_q <= ~|w_d;
      neg_q <= w_d[WIDTH-1];
    end
  end

  assign w   = w_q;
  assign zer = zer_q;
  assign neg = neg_q;
endmodule

// File: tb/tb_alu16_flags.sv
module tb_alu16_flags;
  logic        clk, rst_n, inc;
  logic [2:0]  opc;
  logic [15:0] ina, inb;
  logic [15:0] q_w, s_w;
  logic        q_z, q_n, s_z, s_n;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] w;
    logic        z;
    logic        n;
    string       name;
  } exp_t;

  exp_t sb[$];

  alu16_flags #(.WIDTH(16)) q2 (
    .clk(clk), .rst_n(rst_n), .opc(opc), .ina(ina), .inb(inb), .inc(inc),
    .w(q_w), .zer(q_z), .neg(q_n)
  );

  alu16_flags_gate #(.WIDTH(16)) syq2 (
    .clk(clk), .rst_n(rst_n), .opc(opc), .ina(ina), .inb(inb), .inc(inc),
    .w(s_w), .zer(s_z), .neg(s_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] aw, input logic az,
                     input logic an, input logic [15:0] ew, input logic ez,
                     input logic en);
    tests++;
    if ({aw, az, an} !== {ew, ez, en}) begin
      fails++;
      $display("FAIL %s: got w=%h zer=%b neg=%b, expected w=%h zer=%b neg=%b",
               nm, aw, az, an, ew, ez, en);
    end
  endtask

  task automatic chk_both(input string nm, input logic [15:0] ew,
                          input logic ez, input logic en);
    chk({nm, " q2"},   q_w, q_z, q_n, ew, ez, en);
    chk({nm, " syq2"}, s_w, s_z, s_n, ew, ez, en);
  endtask

  // Drive one op at the falling edge; its result is due at the next rise.
  task automatic drive(input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic [15:0] ew, input string nm,
                       input bit in_rst = 1'b0);
    exp_t e;
    @(negedge clk);
    opc = o; ina = a; inb = b; inc = c;
    e.w    = in_rst ? 16'h0000 : ew;
    e.z    = in_rst ? 1'b1 : (ew == 16'h0000);
    e.n    = in_rst ? 1'b0 : ew[15];
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic rst_pulse(input string nm);
    #1 rst_n = 1'b0;
    #1 chk_both(nm, 16'h0000, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] model(input logic [2:0] o,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic c);
    case (o)
      3'd0: return a + b + {15'd0, c};
      3'd1: return a - b - {15'd0, c};
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {a[14:0], c};
      default: return {a[15], a[15:1]};
    endcase
  endfunction

  // Monitor: every rising edge, pop the due result, check it just after the
  // edge and again late in the high phase to confirm it holds.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_both(e.name, e.w, e.z, e.n);
        #3;
        chk_both({e.name, " hold"}, e.w, e.z, e.n);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL timeout: simulation exceeded time budget, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    rst_n = 1'b1; opc = 3'd0; ina = 16'd5; inb = 16'd7; inc = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_both("reset_async", 16'h0000, 1'b1, 1'b0);

    // Clocks toggle during reset with a live ADD on the inputs.
    drive(3'd0, 16'd5, 16'd7, 1'b0, 16'h0000, "reset_hold0", 1'b1);
    drive(3'd0, 16'd5, 16'd7, 1'b0, 16'h0000, "reset_hold1", 1'b1);
    drive(3'd0, 16'd5, 16'd7, 1'b0, 16'h000C, "reset_release");
    #1 rst_n = 1'b1;

    drive(3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, "add_wrap");
    drive(3'd1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, "sub_borrow");
    drive(3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, "sub_underflow");
    drive(3'd0, 16'h0001, 16'h0002, 1'b1, 16'h0004, "add_cin");
    drive(3'd2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, "and");
    drive(3'd3, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFFF0, "or");
    drive(3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFF00, "xor");
    drive(3'd5, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, "not");
    drive(3'd6, 16'h8001, 16'hBEEF, 1'b1, 16'h0003, "shl");
    drive(3'd7, 16'h8002, 16'hFFFF, 1'b1, 16'hC001, "sar_neg");
    drive(3'd7, 16'h0001, 16'hFFFF, 1'b1, 16'h0000, "sar_zero");

    // Back-to-back sweep of all opcodes, operands change every cycle.
    drive(3'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, "lat_add");
    drive(3'd1, 16'h5000, 16'h0001, 1'b0, 16'h4FFF, "lat_sub");
    drive(3'd2, 16'hFFFF, 16'hA5A5, 1'b0, 16'hA5A5, "lat_and");
    drive(3'd3, 16'h0000, 16'h0000, 1'b0, 16'h0000, "lat_or");
    drive(3'd4, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, "lat_xor");
    drive(3'd5, 16'h0F0F, 16'h0000, 1'b0, 16'hF0F0, "lat_not");
    drive(3'd6, 16'h4000, 16'h0000, 1'b0, 16'h8000, "lat_shl");
    drive(3'd7, 16'h4000, 16'h0000, 1'b0, 16'h2000, "lat_sar");

    // Random operands across the opcode sweep, with an async reset pulse
    // between edges partway through.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      drive(3'(i % 8), ra, rb, rc, model(3'(i % 8), ra, rb, rc),
            $sformatf("rand%0d", i));
      if (i == 10) rst_pulse("reset_midstream");
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu16_flags.md
Name: alu16_flags

Overview:
- 16-bit, 8-operation ALU with zero and negative status flags, outputs registered on a single clock.
- Serves as the datapath execute unit: operands and operation code arrive each cycle; result and flags appear one clock later.
- Two implementations must be bit-identical on every output in every cycle: a behavioural version and a structural/gate-level version, named q2 and syq2 at integration.

Parameters:
- WIDTH, 16, operand and result width; all rules below are written for 16 and scale with WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opc  input  3  operation select.
- ina  input  16  operand A.
- inb  input  16  operand B.
- inc  input  1  carry/borrow/shift-in bit.
- w  output  16  registered result.
- zer  output  1  registered zero flag.
- neg  output  1  registered negative flag.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low forces w=16'h0000, zer=1, neg=0 immediately, without waiting for a clock edge.
  - Outputs hold these values while rst_n is low.
  - The first capture happens at the first rising clk edge after rst_n goes high.
- Latency:
  - On each rising clk edge with rst_n high, w, zer and neg load the values computed from the current opc, ina, inb and inc.
  - Latency is exactly 1 cycle. There is no handshake and no stall; a new operation can start every cycle.
- Operations (all arithmetic is modulo 2^16; carry-out and overflow are discarded):
  - 000 ADD: w = ina + inb + inc.
  - 001 SUB: w = ina - inb - inc (two's complement; inc acts as borrow-in).
  - 010 AND: w = ina & inb.
  - 011 OR: w = ina | inb.
  - 100 XOR: w = ina ^ inb.
  - 101 NOT: w = ~ina. inb and inc are ignored.
  - 110 SHL: w = {ina[14:0], inc}. inb is ignored.
  - 111 SAR: w = {ina[15], ina[15:1]}. inb and inc are ignored.
- Flags:
  - Both flags are derived from the next result value and registered on the same edge as w.
  - zer = 1 iff next w == 16'h0000.
  - neg = next w[15].
- X handling: operands not used by the selected opc must not affect any output.
- Boundary cases:
  - ADD wrap: 16'hFFFF + 16'h0001 + 0 gives w=0, zer=1, neg=0.
  - SUB underflow: 0 - 1 - 0 gives w=16'hFFFF, neg=1.
  - Reset asserted mid-stream clears outputs asynchronously.
  - Reset deasserted coincident with a clk edge: that edge must not capture; capture starts at the next edge.
- The behavioural and structural versions must be cycle-exact equivalent on w, zer and neg for all 2^36 input combinations and across reset.

Test Plan:
- Reset: hold rst_n=0, apply ADD with ina=5, inb=7 and toggle clk -> w=0, zer=1, neg=0 throughout. Release rst_n -> one edge later w=16'h000C, zer=0, neg=0.
- ADD/SUB:
  - ADD ina=16'hFFFF, inb=16'h0001, inc=0 -> w=0, zer=1.
  - SUB ina=16'h0003, inb=16'h0005, inc=1 -> w=16'hFFFD, neg=1.
- Logic:
  - AND 16'hF0F0,16'h0FF0 -> 16'h00F0.
  - OR -> 16'hFFF0 (neg=1).
  - XOR -> 16'hFF00.
  - NOT ina=16'hFFFF -> w=0, zer=1.
- Shifts:
  - SHL ina=16'h8001, inc=1 -> 16'h0003.
  - SAR ina=16'h8002 -> 16'hC001, neg=1.
  - SAR ina=16'h0001 -> 0, zer=1.
- Latency: change ina, inb and opc every cycle across all 8 opcodes -> each result appears exactly one edge later and is stable between edges.
- Equivalence: 20+ random {ina, inb, inc} vectors while sweeping opc 000..111, driven to both implementations -> w, zer and neg match every cycle, including an asynchronous reset pulse between edges.
